// File: rtl/mobius_iter.sv
// -----------------------------------------------------------------------------
// mobius_iter
//
// Iterative GF(2) Mobius transform over an N-bit vector.
//   out_data[j] = XOR of in_data[i] for every i whose index bits are a subset
//   of j's index bits. The transform is its own inverse, so the same block
//   converts ANF -> truth table and truth table -> ANF.
//
// One N-bit working register is reused across log2_N cycles. Each cycle one
// butterfly stage (selected by the stage counter) is applied to the register.
// Stage s works on index bit (log2_N-1-s):
//   h = N >> (s+1)
//   reg[p] ^= reg[p-h] for every p that has the h bit set.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   synchronous, active-high reset
//   in_valid   in   in_data holds a vector to transform
//   in_ready   out  a vector is accepted this cycle when in_valid is also high
//   in_data    in   [0:N-1] input vector, index 0 is the leftmost bit
//   out_valid  out  out_data holds a completed result
//   out_ready  in   consumer takes the result this cycle
//   out_data   out  [0:N-1] result vector, same index order as in_data
//
// Timing
//   A vector accepted at edge t is presented with out_valid high after edge
//   t+log2_N. A result taken with a new vector waiting starts the next vector
//   on the same edge, so the sustained rate is one vector per log2_N+1 cycles.
// -----------------------------------------------------------------------------
module mobius_iter #(
  parameter int N      = 2048,
  parameter int log2_N = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:N-1] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:N-1] out_data
);

  // Stage counter must hold 0..log2_N-1; keep at least one bit for N=2.
  localparam int CW = (log2_N > 1) ? $clog2(log2_N) : 1;
  localparam logic [CW-1:0] LAST_STAGE = CW'(log2_N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] stage_q, stage_d;
  logic [0:N-1]  data_q,  data_d;

  // Result of every possible stage applied to the current register. Only the
  // one selected by stage_q is used; the rest is simple XOR wiring.
  logic [0:N-1]  stage_res [log2_N];
  logic [0:N-1]  stage_out;

  // ---------------------------------------------------------------------------
  // Butterfly stage network
  // ---------------------------------------------------------------------------
  for (genvar gs = 0; gs < log2_N; gs++) begin : g_stage
    localparam int H = N >> (gs + 1);
    for (genvar gi = 0; gi < N; gi++) begin : g_bit
      if ((gi & H) != 0) begin : g_upper
        // Upper half of a 2h block picks up its partner in the lower half.
        assign stage_res[gs][gi] = data_q[gi] ^ data_q[gi - H];
      end else begin : g_lower
        assign stage_res[gs][gi] = data_q[gi];
      end
    end
  end

  // Select the stage for the current counter value.
  always_comb begin
    stage_out = data_q;
    for (int s = 0; s < log2_N; s++) begin
      if (stage_q == CW'(s)) begin
        stage_out = stage_res[s];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control: next state, next register contents and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    data_d    = data_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d  = in_data;
          stage_d = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        data_d = stage_out;
        if (stage_q == LAST_STAGE) begin
          stage_d = '0;
          state_d = DONE;
        end else begin
          stage_d = stage_q + CW'(1);
        end
      end

      DONE: begin
        out_valid = 1'b1;
        // The register is free exactly when the result is being taken, so a
        // waiting vector can load on the same edge. This is the only
        // input-to-output combinational path and it is deliberate.
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            data_d  = in_data;
            stage_d = '0;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        stage_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      stage_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      data_q  <= data_d;
    end
  end

  // Result comes straight from the working register.
  assign out_data = data_q;

endmodule

// File: tb/tb_mobius_iter.sv
// -----------------------------------------------------------------------------
// tb_mobius_iter
//
// Scoreboard bench for mobius_iter. Two instances run side by side:
//   u_dut8    N=8,    log2_N=3   directed cases, handshake timing, reset,
//                                1000 random vectors with involution
//   u_dut2048 N=2048, log2_N=11  random vectors with involution, known vector
// Expected results are pushed to a queue on accept and popped when the DUT
// presents a result that is being taken.
// -----------------------------------------------------------------------------
module tb_mobius_iter;

  localparam int NS = 8;
  localparam int LS = 3;
  localparam int NB = 2048;
  localparam int LB = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int n_tx8  = 0;
  int n_txb  = 0;

  // ---------------- N=8 instance ----------------
  logic          rst;
  logic          in_valid8, in_ready8, out_valid8, out_ready8;
  logic [0:NS-1] in_data8, out_data8;

  mobius_iter #(.N(NS), .log2_N(LS)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .in_data   (in_data8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .out_data  (out_data8)
  );

  // ---------------- N=2048 instance ----------------
  logic          rstb;
  logic          in_validb, in_readyb, out_validb, out_readyb;
  logic [0:NB-1] in_datab, out_datab;

  mobius_iter #(.N(NB), .log2_N(LB)) u_dut2048 (
    .clk       (clk),
    .rst       (rstb),
    .in_valid  (in_validb),
    .in_ready  (in_readyb),
    .in_data   (in_datab),
    .out_valid (out_validb),
    .out_ready (out_readyb),
    .out_data  (out_datab)
  );

  logic [0:NS-1] exp8_q [$];
  logic [0:NB-1] expb_q [$];
  logic [0:NS-1] last_out8;
  logic [0:NB-1] last_outb;
  logic [0:NS-1] e8;
  logic [0:NB-1] eb;
  logic          big_done = 1'b0;

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_big(input string tag, input logic [0:NB-1] got, input logic [0:NB-1] exp);
    for (int w = 0; w < NB / 64; w++) begin
      check_val($sformatf("%s_w%0d", tag, w), got[w*64 +: 64], exp[w*64 +: 64]);
    end
  endtask

  // ---------------- models ----------------
  // Direct subset definition.
  function automatic logic [0:NS-1] model8(input logic [0:NS-1] v);
    logic [0:NS-1] r;
    r = '0;
    for (int j = 0; j < NS; j++)
      for (int i = 0; i < NS; i++)
        if ((i & j) == i) r[j] = r[j] ^ v[i];
    return r;
  endfunction

  // In-place transform, one index bit at a time (bit order is irrelevant).
  function automatic logic [0:NB-1] model_big(input logic [0:NB-1] v);
    logic [0:NB-1] r;
    r = v;
    for (int k = 0; k < LB; k++)
      for (int i = 0; i < NB; i++)
        if (i[k]) r[i] = r[i] ^ r[i ^ (1 << k)];
    return r;
  endfunction

  function automatic logic [0:NB-1] rand_big();
    logic [0:NB-1] r;
    for (int w = 0; w < NB / 32; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (!rst && out_valid8 && out_ready8) begin
      if (exp8_q.size() == 0) begin
        check_val("n8_unexpected_result", 64'(exp8_q.size()), 64'd1);
      end else begin
        e8 = exp8_q.pop_front();
        n_tx8++;
        $display("tx n8 #%0d result=%h expected=%h", n_tx8, out_data8, e8);
        check_val("n8_result", 64'(out_data8), 64'(e8));
        last_out8 = out_data8;
      end
    end
  end

  always @(negedge clk) begin
    if (!rstb && out_validb && out_readyb) begin
      if (expb_q.size() == 0) begin
        check_val("n2048_unexpected_result", 64'(expb_q.size()), 64'd1);
      end else begin
        eb = expb_q.pop_front();
        n_txb++;
        $display("tx n2048 #%0d word0=%h expected_word0=%h", n_txb, out_datab[0 +: 64], eb[0 +: 64]);
        check_big("n2048_result", out_datab, eb);
        last_outb = out_datab;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send8(input logic [0:NS-1] v, input bit wiggle);
    int c;
    @(posedge clk); #1;
    in_valid8 = 1'b1;
    in_data8  = v;
    c = 0;
    @(negedge clk);
    while (!in_ready8 && c < 40) begin
      c++;
      @(negedge clk);
    end
    if (!in_ready8) check_val("n8_accept_timeout", 64'(in_ready8), 64'd1);
    exp8_q.push_back(model8(v));
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    if (wiggle) begin
      for (int k = 0; k <= LS; k++) begin
        in_data8 = NS'($urandom);
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic drain8();
    int c;
    c = 0;
    while (exp8_q.size() != 0 && c < 200) begin
      @(negedge clk);
      c++;
    end
    if (exp8_q.size() != 0) check_val("n8_drain_timeout", 64'(exp8_q.size()), 64'd0);
  endtask

  task automatic sendb(input logic [0:NB-1] v);
    int c;
    @(posedge clk); #1;
    in_validb = 1'b1;
    in_datab  = v;
    c = 0;
    @(negedge clk);
    while (!in_readyb && c < 60) begin
      c++;
      @(negedge clk);
    end
    if (!in_readyb) check_val("n2048_accept_timeout", 64'(in_readyb), 64'd1);
    expb_q.push_back(model_big(v));
    @(posedge clk); #1;
    in_validb = 1'b0;
    in_datab  = rand_big();
  endtask

  task automatic drainb();
    int c;
    c = 0;
    while (expb_q.size() != 0 && c < 200) begin
      @(negedge clk);
      c++;
    end
    if (expb_q.size() != 0) check_val("n2048_drain_timeout", 64'(expb_q.size()), 64'd0);
  endtask

  // ---------------- N=2048 stimulus ----------------
  initial begin : big_seq
    logic [0:NB-1] xv, yv, ones;
    rstb       = 1'b1;
    in_validb  = 1'b0;
    in_datab   = '0;
    out_readyb = 1'b1;
    repeat (3) @(posedge clk);
    #1 rstb = 1'b0;
    @(negedge clk);
    check_val("n2048_rst_in_ready", 64'(in_readyb), 64'd1);
    check_val("n2048_rst_out_valid", 64'(out_validb), 64'd0);

    // Only index 0 set: every output index contains 0 as a subset.
    xv    = '0;
    xv[0] = 1'b1;
    ones  = '1;
    sendb(xv);
    drainb();
    check_big("n2048_bit0", last_outb, ones);

    for (int t = 0; t < 12; t++) begin
      xv = rand_big();
      sendb(xv);
      drainb();
      yv = last_outb;
      sendb(yv);
      drainb();
      check_big("n2048_involution", last_outb, xv);
    end
    big_done = 1'b1;
  end

  // ---------------- N=8 stimulus and summary ----------------
  initial begin : main_seq
    logic [0:NS-1] xa, xb, ya;
    int c;
    rst        = 1'b1;
    in_valid8  = 1'b0;
    in_data8   = '0;
    out_ready8 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("rst_out_valid", 64'(out_valid8), 64'd0);
    check_val("rst_in_ready", 64'(in_ready8), 64'd1);
    check_val("rst_out_data", 64'(out_data8), 64'd0);

    // Single bit at index 0 -> all ones, with exact latency.
    send8(8'b1000_0000, 1'b0);
    for (int k = 1; k <= LS; k++) begin
      @(negedge clk);
      check_val($sformatf("latency_low_%0d", k), 64'(out_valid8), 64'd0);
    end
    @(negedge clk);
    check_val("latency_high", 64'(out_valid8), 64'd1);
    check_val("vec_80", 64'(out_data8), 64'hFF);
    drain8();

    send8(8'b0100_0000, 1'b0);
    drain8();
    check_val("vec_40", 64'(last_out8), 64'h55);
    send8(8'b0000_0001, 1'b0);
    drain8();
    check_val("vec_01", 64'(last_out8), 64'h01);
    send8(8'h00, 1'b0);
    drain8();
    check_val("vec_00", 64'(last_out8), 64'h00);
    send8(8'hFF, 1'b0);
    drain8();
    check_val("vec_ff", 64'(last_out8), 64'h80);

    // Input changes every cycle while running; only the accepted value counts.
    send8(8'h5A, 1'b1);
    drain8();
    check_val("sample_once", 64'(last_out8), 64'(model8(8'h5A)));

    // Back-pressure hold, then back-to-back accept.
    out_ready8 = 1'b0;
    xa = 8'hA7;
    xb = 8'h3C;
    send8(xa, 1'b0);
    c = 0;
    @(negedge clk);
    while (!out_valid8 && c < 20) begin
      c++;
      @(negedge clk);
    end
    check_val("hold_reach_done", 64'(out_valid8), 64'd1);
    in_valid8 = 1'b1;
    in_data8  = xb;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_val("hold_out_valid", 64'(out_valid8), 64'd1);
      check_val("hold_in_ready", 64'(in_ready8), 64'd0);
      check_val("hold_out_data", 64'(out_data8), 64'(model8(xa)));
    end
    @(posedge clk); #1;
    out_ready8 = 1'b1;
    exp8_q.push_back(model8(xb));
    @(negedge clk);
    check_val("b2b_in_ready", 64'(in_ready8), 64'd1);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    for (int k = 1; k <= LS; k++) begin
      @(negedge clk);
      check_val("b2b_gap", 64'(out_valid8), 64'd0);
    end
    @(negedge clk);
    check_val("b2b_done", 64'(out_valid8), 64'd1);
    drain8();

    // Reset while stage 1 is pending discards the vector.
    send8(8'h96, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp8_q.delete();
    @(negedge clk);
    check_val("run_rst_out_valid", 64'(out_valid8), 64'd0);
    check_val("run_rst_in_ready", 64'(in_ready8), 64'd1);
    check_val("run_rst_out_data", 64'(out_data8), 64'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_val("run_rst_no_pulse", 64'(out_valid8), 64'd0);
    end
    send8(8'h2D, 1'b0);
    drain8();
    check_val("post_rst_vec", 64'(last_out8), 64'(model8(8'h2D)));

    // Random vectors with involution round trip.
    for (int t = 0; t < 1000; t++) begin
      xa = NS'($urandom);
      send8(xa, (t % 4) == 0);
      drain8();
      ya = last_out8;
      send8(ya, 1'b0);
      drain8();
      check_val("involution", 64'(last_out8), 64'(xa));
    end

    c = 0;
    while (!big_done && c < 20000) begin
      @(posedge clk);
      c++;
    end
    check_val("n2048_finished", 64'(big_done), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
